store_byte_serializer: RTL

Store-path unit for the 64-bit ARM datapath that narrows a 64-bit register value to the STUR/STURW/STURH/STURB access size and writes it to the byte-wide data-memory port one byte per handshake, little-endian. It is the store-side counterpart of the load path's sign extension. It also flags when the stored value does not survive narrowing, meaning the value is not the sign extension of its low bytes. It sits between the EX/MEM register and the data-memory write port.

---
 rtl/store_pkg.sv | 24 ++
 rtl/fit_check.sv | 28 ++
 rtl/store_byte_serializer.sv | 131 +++++++++++++
 3 files changed

// File: rtl/store_pkg.sv
// Shared types for the store path.
//   size_t      : access size encoding (byte, half, word, double)
//   state_t     : serializer FSM states
//   size_nbytes : number of bytes moved for a given access size
package store_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10,
    SZ_X = 2'b11
  } size_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    SEND = 2'b01,
    DONE = 2'b10
  } state_t;

  function automatic logic [3:0] size_nbytes(input size_t sz);
    return 4'd1 << sz;
  endfunction

endpackage

// File: rtl/fit_check.sv
// Combinational range check: does a 64-bit value survive narrowing to the
// given access size, i.e. is it the sign extension of its low bytes?
//   data     in  64  value to test
//   size     in  2   access size
//   overflow out 1   1 when the value does not fit the access size
module fit_check
  import store_pkg::*;
(
  input  logic [63:0] data,
  input  size_t       size,
  output logic        overflow
);

  logic signed [63:0] value;
  logic signed [63:0] narrowed;

  always_comb begin
    value = $signed(data);
    unique case (size)
      SZ_B:    narrowed = $signed({{56{data[7]}},  data[7:0]});
      SZ_H:    narrowed = $signed({{48{data[15]}}, data[15:0]});
      SZ_W:    narrowed = $signed({{32{data[31]}}, data[31:0]});
      default: narrowed = value;
    endcase
    overflow = (narrowed != value);
  end

endmodule

// File: rtl/store_byte_serializer.sv
// Store-path serializer: narrows a 64-bit register value to the access size
// and writes it one byte per handshake, little-endian, to a byte-wide memory
// port. Flags values that do not survive narrowing.
//   clk, reset_n            clock, asynchronous active-low reset
//   req_valid/req_ready     request handshake
//   req_addr/data/size      base address, register value, access size
//   mem_valid/mem_ready     byte-write handshake
//   mem_addr/mem_wdata      address and data of the current byte
//   done                    one-cycle completion pulse
//   trunc_err               narrowing overflow, meaningful while done=1
//   busy                    unit is not idle
module store_byte_serializer
  import store_pkg::*;
#(
  parameter int ADDR_W = 64
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [63:0]       req_data,
  input  logic [1:0]        req_size,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              done,
  output logic              trunc_err,
  output logic              busy
);

  state_t            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [63:0]       data_q;
  size_t             size_q;
  logic [2:0]        idx_q;
  logic              req_ready_q;
  logic              mem_valid_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [7:0]        mem_wdata_q;
  logic              done_q;
  logic              trunc_err_q;
  logic              busy_q;

  logic [2:0]        idx_d;
  logic              last_byte;
  logic              overflow;

  // Range check runs on the latched value, so the flag reflects exactly
  // what was written to memory.
  fit_check u_fit (
    .data     (data_q),
    .size     (size_q),
    .overflow (overflow)
  );

  always_comb begin
    idx_d     = idx_q + 3'd1;
    last_byte = (idx_q == 3'(size_nbytes(size_q) - 4'd1));
  end

  // Outputs are registered and loaded together with the state transition,
  // so the first byte is on the port the cycle after acceptance.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      data_q      <= '0;
      size_q      <= SZ_B;
      idx_q       <= '0;
      req_ready_q <= 1'b1;
      mem_valid_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      done_q      <= 1'b0;
      trunc_err_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req_valid) begin
            addr_q      <= req_addr;
            data_q      <= req_data;
            size_q      <= size_t'(req_size);
            idx_q       <= '0;
            mem_valid_q <= 1'b1;
            mem_addr_q  <= req_addr;
            mem_wdata_q <= req_data[7:0];
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= SEND;
          end
        end
        SEND: begin
          // A stalled byte simply keeps the registered address/data.
          if (mem_ready) begin
            if (last_byte) begin
              mem_valid_q <= 1'b0;
              done_q      <= 1'b1;
              trunc_err_q <= overflow;
              state_q     <= DONE;
            end else begin
              idx_q       <= idx_d;
              // Address arithmetic wraps modulo 2^ADDR_W.
              mem_addr_q  <= addr_q + ADDR_W'(idx_d);
              mem_wdata_q <= data_q[{idx_d, 3'b000} +: 8];
            end
          end
        end
        DONE: begin
          done_q      <= 1'b0;
          trunc_err_q <= 1'b0;
          req_ready_q <= 1'b1;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign mem_valid = mem_valid_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign done      = done_q;
  assign trunc_err = trunc_err_q;
  assign busy      = busy_q;

endmodule
